// File: rtl/dbg_guv_log_arb_if.sv
// dbg_guv_log_arb_if
//   AXI-Stream log bundle around the log arbiter: N_IN flattened inputs on
//   one side, one merged output on the other.
//   Modports:
//     slave  - the arbiter: consumes in_*, out_TREADY; drives in_TREADY, out_*
//     master - the environment: drives in_*, out_TREADY; observes the rest
interface dbg_guv_log_arb_if #(
  parameter int N_IN       = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int DATA_WIDTH = 72
);
  logic [N_IN*DATA_WIDTH-1:0] in_TDATA;
  logic [N_IN-1:0]            in_TVALID;
  logic [N_IN-1:0]            in_TREADY;
  logic [N_IN-1:0]            in_TLAST;
  logic [DATA_WIDTH-1:0]      out_TDATA;
  logic                       out_TVALID;
  logic                       out_TREADY;
  logic                       out_TLAST;
  logic [SEL_WIDTH-1:0]       out_TDEST;

  modport slave (
    input  in_TDATA, in_TVALID, in_TLAST, out_TREADY,
    output in_TREADY, out_TDATA, out_TVALID, out_TLAST, out_TDEST
  );

  modport master (
    output in_TDATA, in_TVALID, in_TLAST, out_TREADY,
    input  in_TREADY, out_TDATA, out_TVALID, out_TLAST, out_TDEST
  );
endinterface

// File: rtl/dbg_guv_log_arb.sv
// dbg_guv_log_arb
//   Round-robin merge of N_IN dbg_guv log streams onto one AXI-Stream output.
//   A grant is taken in IDLE (one bubble cycle) and the granted input is then
//   passed through combinationally; out_TDEST carries the granted index.
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - dbg_guv_log_arb_if.slave (in_TDATA/in_TVALID/in_TLAST/in_TREADY,
//            out_TDATA/out_TVALID/out_TLAST/out_TDEST/out_TREADY)
//
//   Build option:
//     DBG_LOG_ARB_PKT_LOCK_EN - defined: hold the grant until a TLAST flit is
//       transferred (packets never interleave). Undefined: release the grant
//       after every output transfer (per-flit interleave, 1 flit / 2 cycles).
module dbg_guv_log_arb #(
  parameter int N_IN       = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int DATA_WIDTH = 72
) (
  input logic               clk,
  input logic               rst,
  dbg_guv_log_arb_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 r_state;
  logic [SEL_WIDTH-1:0]   r_grant;
  logic [SEL_WIDTH-1:0]   r_last;

  logic                   w_busy;
  logic                   w_found;
  logic [SEL_WIDTH-1:0]   w_next;
  logic                   w_vld;
  logic                   w_lst;
  logic [DATA_WIDTH-1:0]  w_data;
  logic                   w_xfer;

  assign w_busy = (r_state == BUSY);

  // Round-robin search: first valid index at last+1, last+2, ... mod N_IN.
  // Written as constant-index compares so no index ever reaches N_IN..2^SEL-1.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    for (int k = 1; k <= N_IN; k++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (!w_found && bus.in_TVALID[i] &&
            (((int'(r_last) + k) % N_IN) == i)) begin
          w_found = 1'b1;
          w_next  = SEL_WIDTH'(i);
        end
      end
    end
  end

  // Granted-input mux.
  always_comb begin
    w_vld  = 1'b0;
    w_lst  = 1'b0;
    w_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (r_grant == SEL_WIDTH'(i)) begin
        w_vld  = bus.in_TVALID[i];
        w_lst  = bus.in_TLAST[i];
        w_data = bus.in_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pass-through in BUSY; IDLE presents nothing and accepts nothing.
  always_comb begin
    bus.out_TVALID = w_busy & w_vld;
    bus.out_TLAST  = w_busy & w_lst;
    bus.out_TDATA  = w_data;
    bus.out_TDEST  = r_grant;
    for (int i = 0; i < N_IN; i++) begin
      bus.in_TREADY[i] = w_busy && (r_grant == SEL_WIDTH'(i)) && bus.out_TREADY;
    end
  end

  assign w_xfer = bus.out_TVALID & bus.out_TREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= SEL_WIDTH'(N_IN - 1);  // input 0 wins first
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_next;
            r_state <= BUSY;
          end
        end
        BUSY: begin
`ifdef DBG_LOG_ARB_PKT_LOCK_EN
          if (w_xfer && bus.out_TLAST) begin
            r_last  <= r_grant;
            r_state <= IDLE;
          end
`else
          if (w_xfer) begin
            r_last  <= r_grant;
            r_state <= IDLE;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_guv_log_arb.sv
module tb_dbg_guv_log_arb;
  localparam int DW = 72;
`ifdef DBG_LOG_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk;
  logic rst;

  dbg_guv_log_arb_if #(.N_IN(4), .SEL_WIDTH(2), .DATA_WIDTH(DW)) bus ();
  dbg_guv_log_arb_if #(.N_IN(3), .SEL_WIDTH(2), .DATA_WIDTH(DW)) bus3 ();

  dbg_guv_log_arb #(.N_IN(4), .SEL_WIDTH(2), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  dbg_guv_log_arb #(.N_IN(3), .SEL_WIDTH(2), .DATA_WIDTH(DW)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Upstream sources: one queue of {last, data} per input. The front of each
  // queue is also the scoreboard entry the output must show for that source.
  logic [DW:0]    q [4][$];
  logic [3:0]     en;
  logic           rdy;
  logic           rst_req;

  // Reference arbitration state (spec rules, plain ints).
  bit m_busy;
  int m_own;
  int m_last;

  int             got_dest [$];
  logic [DW-1:0]  got_data [$];
  logic           cyc_vld  [$];
  logic [DW-1:0]  cyc_data [$];
  logic [3:0]     cyc_rdy  [$];

  bit   w3_on;
  int   w3_dest [$];
  logic [DW-1:0] w3_data [$];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(int i, int n, logic [DW-1:0] base);
    for (int j = 0; j < n; j++) q[i].push_back({(j == n - 1), base + DW'(j)});
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) q[i].delete();
    got_dest.delete(); got_data.delete();
    cyc_vld.delete(); cyc_data.delete(); cyc_rdy.delete();
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic step();
    logic [3:0] vld;
    logic [3:0] erdy;
    bit ev;
    bit xfer;
    bit lastf;
    for (int i = 0; i < 4; i++) begin
      vld[i] = en[i] && (q[i].size() > 0);
      bus.in_TVALID[i] = vld[i];
      bus.in_TLAST[i]  = vld[i] ? q[i][0][DW] : 1'b0;
      bus.in_TDATA[i*DW +: DW] = vld[i] ? q[i][0][DW-1:0] : '0;
    end
    bus.out_TREADY = rdy;
    rst = rst_req;
    @(negedge clk);
    ev   = m_busy && vld[m_own];
    xfer = ev && rdy;
    if (!rst_req) begin
      erdy = (m_busy && rdy) ? (4'b0001 << m_own) : 4'b0000;
      check("out_TVALID", 128'(bus.out_TVALID), 128'(ev));
      check("in_TREADY", 128'(bus.in_TREADY), 128'(erdy));
      if (ev) begin
        check("out_TDEST", 128'(bus.out_TDEST), 128'(m_own));
        check("out_TDATA", 128'(bus.out_TDATA), 128'(q[m_own][0][DW-1:0]));
        check("out_TLAST", 128'(bus.out_TLAST), 128'(q[m_own][0][DW]));
      end
      cyc_vld.push_back(bus.out_TVALID);
      cyc_data.push_back(bus.out_TDATA);
      cyc_rdy.push_back(bus.in_TREADY);
    end
    @(posedge clk);
    if (rst_req) begin
      m_busy = 0; m_own = 0; m_last = 3;
    end else if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_last + k) % 4;
        if (vld[idx]) begin
          m_busy = 1; m_own = idx;
          break;
        end
      end
    end else if (xfer) begin
      got_dest.push_back(m_own);
      got_data.push_back(q[m_own][0][DW-1:0]);
      lastf = q[m_own][0][DW];
      void'(q[m_own].pop_front());
      if (!LOCK || lastf) begin
        m_last = m_own; m_busy = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_req = 1'b1; step(); rst_req = 1'b0;
  endtask

  task automatic run_until(int n, int bound, string name);
    int c = 0;
    while (got_dest.size() < n && c < bound) begin step(); c++; end
    check(name, 128'(got_dest.size() >= n), 128'(1));
  endtask

  always @(negedge clk) begin
    if (w3_on && bus3.out_TVALID && bus3.out_TREADY) begin
      w3_dest.push_back(int'(bus3.out_TDEST));
      w3_data.push_back(bus3.out_TDATA);
    end
  end

  typedef struct { logic [3:0] mask; int exp_dest; } vec_t;
  vec_t tbl [6];

  initial begin
    bit exp_pat [7];
    int s0;
    int seq;
    int c;
    bit empty;

    // First grant after reset (last = 3, so search starts at 0).
    tbl[0] = '{4'b0010, 1};
    tbl[1] = '{4'b1100, 2};
    tbl[2] = '{4'b1000, 3};
    tbl[3] = '{4'b1111, 0};
    tbl[4] = '{4'b1010, 1};
    tbl[5] = '{4'b0101, 0};

    en = 4'hF; rdy = 1'b1; rst_req = 1'b0; rst = 1'b1;
    m_busy = 0; m_own = 0; m_last = 3;
    w3_on = 1'b0;
    bus3.in_TVALID = '0; bus3.in_TLAST = 3'b111; bus3.out_TREADY = 1'b1;
    for (int i = 0; i < 3; i++) bus3.in_TDATA[i*DW +: DW] = DW'(8'h50 + i);

    // Reset state
    clear_all();
    do_reset();
    do_reset();
    check("rst_out_TVALID", 128'(bus.out_TVALID), 128'(0));
    check("rst_in_TREADY",  128'(bus.in_TREADY),  128'(0));
    check("rst_out_TLAST",  128'(bus.out_TLAST),  128'(0));
    check("rst_out_TDEST",  128'(bus.out_TDEST),  128'(0));

    // Table: first grant from reset for several request masks
    for (int t = 0; t < 6; t++) begin
      clear_all(); do_reset();
      for (int i = 0; i < 4; i++)
        if (tbl[t].mask[i]) push_pkt(i, 1, DW'(16'h100 * (i + 1)));
      step();
      check("tbl_idle_vld", 128'(cyc_vld[0]), 128'(0));
      check("tbl_idle_rdy", 128'(cyc_rdy[0]), 128'(0));
      step();
      check("tbl_grant", 128'(got_dest.size() > 0 ? got_dest[0] : -1), 128'(tbl[t].exp_dest));
    end

    // Single input, 3-flit packet
    clear_all(); do_reset();
    push_pkt(1, 3, DW'('hA));
    for (int s = 0; s < 7; s++) step();
    if (LOCK) exp_pat = '{0, 1, 1, 1, 0, 0, 0};
    else      exp_pat = '{0, 1, 0, 1, 0, 1, 0};
    for (int s = 0; s < 7; s++) check("single_vld_pattern", 128'(cyc_vld[s]), 128'(exp_pat[s]));
    check("single_count", 128'(got_data.size()), 128'(3));
    for (int j = 0; j < 3 && j < got_data.size(); j++) begin
      check("single_data", 128'(got_data[j]), 128'('hA + j));
      check("single_dest", 128'(got_dest[j]), 128'(1));
    end

    // Fairness: all inputs always valid, 1-flit packets
    clear_all(); do_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) push_pkt(i, 1, DW'(i * 16 + j));
    run_until(6, 40, "fair_timeout");
    for (int j = 0; j < 6 && j < got_dest.size(); j++)
      check("fair_order", 128'(got_dest[j]), 128'(j % 4));

    // Packet lock vs per-flit interleave
    clear_all(); do_reset();
    push_pkt(0, 4, DW'('h00));
    push_pkt(2, 2, DW'('h20));
    run_until(6, 40, "lock_timeout");
    for (int j = 0; j < 6 && j < got_dest.size(); j++) begin
      int e;
      if (LOCK) e = (j < 4) ? 0 : 2;
      else      e = (j < 4) ? ((j % 2) * 2) : 0;
      check("lock_order", 128'(got_dest[j]), 128'(e));
    end

    // Backpressure mid-packet
    clear_all(); do_reset();
    push_pkt(3, 4, DW'('h30));
    run_until(2, 20, "bp_timeout");
    rdy = 1'b0;
    s0 = cyc_vld.size();
    for (int s = 0; s < 5; s++) step();
    check("bp_no_xfer", 128'(got_data.size()), 128'(2));
    check("bp_held_vld", 128'(cyc_vld[s0 + 4]), 128'(1));
    check("bp_held_data", 128'(cyc_data[s0 + 4]), 128'('h32));
    check("bp_rdy_low", 128'(cyc_rdy[s0 + 4]), 128'(0));
    rdy = 1'b1;
    run_until(4, 20, "bp_drain_timeout");
    check("bp_count", 128'(got_data.size()), 128'(4));
    for (int j = 0; j < 4 && j < got_data.size(); j++)
      check("bp_data", 128'(got_data[j]), 128'('h30 + j));

    // Reset mid-packet
    clear_all(); do_reset();
    push_pkt(1, 4, DW'('h10));
    run_until(2, 20, "rstmid_timeout");
    push_pkt(0, 1, DW'('h40));
    rdy = 1'b0;
    do_reset();
    rdy = 1'b1;
    s0 = cyc_vld.size();
    step();
    check("rstmid_idle_vld", 128'(cyc_vld[s0]), 128'(0));
    run_until(5, 30, "rstmid_drain_timeout");
    if (got_dest.size() >= 5) begin
      check("rstmid_next_grant", 128'(got_dest[2]), 128'(0));
      check("rstmid_next_data",  128'(got_data[2]), 128'('h40));
      check("rstmid_rest_data",  128'(got_data[3]), 128'('h12));
      check("rstmid_rest_dest",  128'(got_dest[4]), 128'(1));
    end

    // Wrap: N_IN=3, all valid
    clear_all(); do_reset();
    w3_dest.delete(); w3_data.delete();
    bus3.in_TVALID = 3'b111;
    w3_on = 1'b1;
    for (int s = 0; s < 10; s++) step();
    w3_on = 1'b0;
    bus3.in_TVALID = 3'b000;
    check("wrap_count", 128'(w3_dest.size() >= 4), 128'(1));
    for (int j = 0; j < 4 && j < w3_dest.size(); j++)
      check("wrap_order", 128'(w3_dest[j]), 128'(j % 3));
    for (int j = 0; j < w3_dest.size(); j++) begin
      check("wrap_no_idx3", 128'(w3_dest[j] < 3), 128'(1));
      check("wrap_data", 128'(w3_data[j]), 128'('h50 + w3_dest[j]));
    end

    // Randomized traffic against the model
    clear_all(); do_reset();
    seq = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = $urandom_range(0, 3);
        if (q[i].size() < 8) begin
          push_pkt(i, $urandom_range(1, 4), {8'(i), 32'(seq), 32'($urandom)});
          seq += 8;
        end
      end
      for (int i = 0; i < 4; i++) en[i] = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      step();
    end
    en = 4'hF; rdy = 1'b1;
    c = 0;
    empty = 0;
    while (!empty && c < 600) begin
      step(); c++;
      empty = (q[0].size() == 0) && (q[1].size() == 0) &&
              (q[2].size() == 0) && (q[3].size() == 0);
    end
    check("rand_drained", 128'(empty), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dbg_guv_log_arb.md
# dbg_guv_log_arb

Round-robin arbiter that merges the log streams of several daisy-chained `dbg_guv` controllers into one AXI-Stream log output for a single capture/offload path. It grants one requester at a time and holds the grant until the end of the packet (`TLAST`), so log packets never interleave. It tags every output flit with the source index on `TDEST`. One instance sits per log-collection point and replaces ad-hoc per-core log wiring.

## Interface
- `N_IN`, 4: number of log inputs, 2..2^`SEL_WIDTH`.
- `SEL_WIDTH`, 2: width of the grant index and `out_TDEST`.
- `DATA_WIDTH`, 72: width of one log flit. Default is 64 data bits plus 8 catted `TKEEP` bits.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_TDATA` in `N_IN*DATA_WIDTH`: flattened log inputs; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_TVALID` in `N_IN`: per-input valid.
- `in_TREADY` out `N_IN`: per-input ready.
- `in_TLAST` in `N_IN`: per-input end of packet.
- `out_TDATA` out `DATA_WIDTH`: selected flit.
- `out_TVALID` out 1: output valid.
- `out_TREADY` in 1: output ready.
- `out_TLAST` out 1: end of packet.
- `out_TDEST` out `SEL_WIDTH`: index of the granted input.

## Operation
- Flit transfer on any port: `TVALID && TREADY` at a rising edge.
- FSM states:
  - IDLE: no grant.
  - BUSY: `grant` register is locked onto one input.
- IDLE:
  - `out_TVALID`=0 and all `in_TREADY`=0.
  - If any `in_TVALID` is set, load `grant` with the first valid index searching `last+1`, `last+2`, …, modulo `N_IN`, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `out_TDATA`/`out_TLAST`/`out_TVALID` = `in_*[grant]`.
  - `out_TDEST` = `grant`.
  - `in_TREADY[grant]` = `out_TREADY`; all other `in_TREADY` = 0.
  - On an output transfer with `out_TLAST`=1: `last` <= `grant`, go to IDLE.
  - Otherwise stay in BUSY. Waiting for a deasserted `in_TVALID[grant]` mid-packet is allowed and has no timeout.
- Round-robin fairness: an input continuously requesting waits at most `N_IN-1` packets.
- Index arithmetic: `SEL_WIDTH` bits, wrap at `N_IN` (not at 2^`SEL_WIDTH`). Indices ≥ `N_IN` are never granted.
- `DATA_WIDTH` passes through unmodified; the block does not interpret the payload.

## Timing
- Reset values:
  - State = IDLE, `grant` = 0, `last` = `N_IN-1` (input 0 has first priority).
  - `out_TVALID` = 0, `in_TREADY` = 0, `out_TLAST` = 0, `out_TDEST` = 0.
- Arbitration latency: a request seen in IDLE at edge k produces `out_TVALID` in the cycle after edge k. This costs one bubble cycle per packet.
- Within a packet: zero latency, combinational pass-through. Full throughput of 1 flit/cycle when `out_TREADY`=1.
- Combinational paths, allowed and required:
  - `in_TVALID[grant]`→`out_TVALID`.
  - `out_TREADY`→`in_TREADY[grant]`.
- No combinational path from any input to `in_TREADY` in IDLE (all zero).
- Backpressure: while `out_TREADY`=0 in BUSY, the output follows the granted input, which by AXIS rules holds its data stable.
- Simultaneous events:
  - Multiple `in_TVALID` rising in the same IDLE cycle: the round-robin order decides.
  - A non-granted input's `TLAST` has no effect.
- Reset mid-packet: the grant is dropped immediately. The upstream remainder of the packet is delivered as a new packet at its next grant; upstream resets together with the arbiter.

## Configuration
- `DBG_LOG_ARB_PKT_LOCK_EN` defined:
  - Grant releases only on a transfer with `out_TLAST`=1.
  - `last` updates only at packet end.
- Not defined:
  - Grant releases after every output transfer regardless of `TLAST`, so flits interleave per flit, each tagged on `out_TDEST`.
  - `last` updates every flit.
  - Every flit incurs the IDLE bubble, so maximum throughput is 1 flit per 2 cycles.
  - Consumers must reassemble packets by `TDEST`.

## Test plan
- Single input: only input 1 valid, 3-flit packet (data 0xA,0xB,0xC, `TLAST` on 0xC), `out_TREADY`=1 → `out_TVALID` one cycle after the request, 0xA/0xB/0xC on consecutive cycles, `out_TDEST`=1, then one IDLE cycle.
- Fairness: all 4 inputs always valid with 1-flit packets (`TLAST`=1) → grant sequence 0,1,2,3,0,1 and `out_TDEST` follows that sequence.
- Packet lock (macro defined): input 0 sends a 4-flit packet while input 2 is valid → 4 flits with `TDEST`=0 and no interleave, then `TDEST`=2. With the macro undefined, the same stimulus gives the order 0,2,0,2.
- Backpressure: `out_TREADY`=0 for 5 cycles mid-packet → `out_TDATA` held, `in_TREADY[grant]`=0, no flit lost or duplicated. Checked with a scoreboard per input.
- Reset mid-packet: `rst` pulsed after flit 2 of 4 → next cycle `out_TVALID`=0 and state IDLE; the next grant goes to input 0 if it is valid.
- Wrap: `N_IN`=3, `SEL_WIDTH`=2, all inputs valid → grants 0,1,2,0; index 3 is never output.
